// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM states, 4-bit opcode map and the
// write-class record produced by the instruction decoder.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StMem,
      StHalt
   } state_e;

   localparam logic [3:0] OpTake   = 4'd0;
   localparam logic [3:0] OpXor    = 4'd1;
   localparam logic [3:0] OpNand   = 4'd2;
   localparam logic [3:0] OpShl    = 4'd3;
   localparam logic [3:0] OpShr    = 4'd4;
   localparam logic [3:0] OpLsn    = 4'd5;
   localparam logic [3:0] OpEql    = 4'd6;
   localparam logic [3:0] OpAdd    = 4'd7;
   localparam logic [3:0] OpSub    = 4'd8;
   localparam logic [3:0] OpPut    = 4'd9;
   localparam logic [3:0] OpOf0    = 4'd10;
   localparam logic [3:0] OpLoad   = 4'd11;
   localparam logic [3:0] OpLookup = 4'd12;
   localparam logic [3:0] OpStore  = 4'd13;
   localparam logic [3:0] OpHalt   = 4'd14;
   localparam logic [3:0] OpTba    = 4'd15;

   typedef struct packed {
      logic acc;
      logic regw;
      logic mem_rd;
      logic mem_wr;
      logic ov_upd;
      logic ov_clr;
      logic halt;
      logic nop;
      logic branch;
   } wr_class_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of the latched instruction into its write class.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [8:0] ir_i,
   output wr_class_t  cls_o
);

   always_comb begin
      cls_o = '0;
      if (ir_i[8]) begin
         cls_o.branch = 1'b1;
      end else begin
         case (ir_i[7:4])
            OpTake, OpXor, OpNand, OpShl, OpShr, OpLsn, OpEql, OpSub: cls_o.acc = 1'b1;
            OpAdd: begin
               cls_o.acc    = 1'b1;
               cls_o.ov_upd = 1'b1;
            end
            OpPut: cls_o.regw = 1'b1;
            OpOf0: begin
               cls_o.ov_clr = 1'b1;
               cls_o.nop    = 1'b1;
            end
            OpLoad, OpLookup: cls_o.mem_rd = 1'b1;
            OpStore:          cls_o.mem_wr = 1'b1;
            OpHalt:           cls_o.halt   = 1'b1;
            default:          cls_o.nop    = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer: fetches 9-bit instructions, steers an external ALU,
// register file and data memory, and tracks PC and the overflow flag.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] pc,
   output logic       imem_req,
   input  logic       imem_valid,
   input  logic [8:0] instr,
   output logic [3:0] alu_op,
   output logic       alu_type,
   input  logic       alu_ov,
   output logic       ov_flag,
   input  logic       acc_nz,
   output logic [3:0] reg_addr,
   output logic       reg_we,
   output logic       acc_we,
   output logic       acc_src_mem,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       busy,
   output logic       halted
);

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [8:0] ir_q, ir_d;
   logic       ov_q, ov_d;
   wr_class_t  cls;
   logic [7:0] pc_inc;

   alu_seq_decode u_decode (
      .ir_i  (ir_q),
      .cls_o (cls)
   );

   assign pc_inc = pc_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ov_d        = ov_q;
      imem_req    = 1'b0;
      acc_we      = 1'b0;
      reg_we      = 1'b0;
      acc_src_mem = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
               ov_d    = 1'b0;
            end
         end
         StFetch: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               ir_d    = instr;
               state_d = StExec;
            end
         end
         StExec: begin
            acc_we = cls.acc;
            reg_we = cls.regw;
            if (cls.ov_upd) ov_d = alu_ov;
            if (cls.ov_clr) ov_d = 1'b0;
            if (cls.halt) begin
               state_d = StHalt;
            end else if (cls.branch) begin
               state_d = StFetch;
               // 8-bit add of the raw offset is the sign-extended add modulo 256.
               pc_d    = acc_nz ? pc_q + ir_q[7:0] : pc_inc;
            end else if (cls.mem_rd || cls.mem_wr) begin
               state_d = StMem;
            end else if (cls.acc || cls.regw || cls.nop) begin
               state_d = StFetch;
               pc_d    = pc_inc;
            end else begin
               state_d = StIdle;
            end
         end
         StMem: begin
            dmem_req = 1'b1;
            dmem_we  = cls.mem_wr;
            if (dmem_ready) begin
               acc_we      = cls.mem_rd;
               acc_src_mem = cls.mem_rd;
               pc_d        = pc_inc;
               state_d     = StFetch;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ov_q    <= ov_d;
      end
   end

   assign pc       = pc_q;
   assign ov_flag  = ov_q;
   assign alu_op   = ir_q[7:4];
   assign alu_type = ir_q[8];
   assign reg_addr = ir_q[3:0];
   assign busy     = (state_q == StFetch) || (state_q == StExec) || (state_q == StMem);
   assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected fetches and write events are
// queued by the stimulus and checked by a monitor on the falling edge.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pc;
   logic       imem_req, imem_valid;
   logic [8:0] instr;
   logic [3:0] alu_op, reg_addr;
   logic       alu_type, alu_ov, ov_flag;
   logic       acc_nz = 1'b0;
   logic       reg_we, acc_we, acc_src_mem, dmem_req, dmem_we;
   logic       dmem_ready = 1'b0;
   logic       busy, halted;

   logic [8:0] imem [256];
   logic       valid_en = 1'b1;
   logic       stall_en = 1'b0;
   logic [7:0] stall_pc = 8'd0;
   logic       ov_in = 1'b0;
   int         st_delay = 0;
   int         ld_delay = 0;
   int         req_cnt = 0;
   int         dreq_cycles = 0;
   int         dwe_cycles = 0;
   int         checks = 0;
   int         failures = 0;

   typedef struct packed {
      logic       acc_we;
      logic       reg_we;
      logic       dmem_we;
      logic       src_mem;
      logic [3:0] raddr;
      logic [7:0] pc;
      logic       ov;
   } wr_exp_t;

   wr_exp_t    wr_q[$];
   logic [7:0] fetch_q[$];

   alu_sequencer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pc          (pc),
      .imem_req    (imem_req),
      .imem_valid  (imem_valid),
      .instr       (instr),
      .alu_op      (alu_op),
      .alu_type    (alu_type),
      .alu_ov      (alu_ov),
      .ov_flag     (ov_flag),
      .acc_nz      (acc_nz),
      .reg_addr    (reg_addr),
      .reg_we      (reg_we),
      .acc_we      (acc_we),
      .acc_src_mem (acc_src_mem),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ready  (dmem_ready),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign instr      = imem[pc];
   assign imem_valid = valid_en && !(stall_en && pc == stall_pc);
   // ALU model: only a type-0 add can overflow.
   assign alu_ov     = ov_in && !alu_type && (alu_op == OpAdd);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Data-memory responder: ready after the configured number of wait cycles.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (dmem_req) req_cnt++;
         else req_cnt = 0;
         dmem_ready = dmem_req && (req_cnt > (dmem_we ? st_delay : ld_delay));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req && imem_valid) begin
            if (fetch_q.size() == 0) chk("fetch_unexpected", 32'(pc), 32'hFFFF);
            else chk("fetch_pc", 32'(pc), 32'(fetch_q.pop_front()));
         end
         if (acc_we || reg_we || (dmem_req && dmem_ready)) begin
            if (wr_q.size() == 0)
               chk("write_unexpected", 32'({acc_we, reg_we, dmem_we, pc}), 32'hFFFF);
            else
               chk("write_event",
                   32'({acc_we, reg_we, dmem_we, acc_src_mem, reg_addr, pc, ov_flag}),
                   32'(wr_q.pop_front()));
         end
         if (dmem_req) dreq_cycles++;
         if (dmem_we) dwe_cycles++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic a, input logic r, input logic w, input logic s,
                          input logic [3:0] ra, input logic [7:0] p, input logic o);
      wr_exp_t e;
      e = '{acc_we: a, reg_we: r, dmem_we: w, src_mem: s, raddr: ra, pc: p, ov: o};
      wr_q.push_back(e);
   endtask

   task automatic push_fetch_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) fetch_q.push_back(8'(i));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      acc_nz = 1'b0;
      ov_in = 1'b0;
      stall_en = 1'b0;
      st_delay = 0;
      ld_delay = 0;
      for (int i = 0; i < 256; i++) imem[i] = {1'b0, OpTba, 4'd0};
      tick(2);
      rst_n = 1'b1;
      tick(1);
      dreq_cycles = 0;
      dwe_cycles = 0;
   endtask

   task automatic wait_halt(output int n);
      n = 0;
      while (!halted && n < 200) begin
         tick(1);
         n++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
   endtask

   task automatic wait_fetch(input logic [7:0] target);
      int  n;
      logic found;
      n = 0;
      found = 1'b0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         found = imem_req && imem_valid && (pc == target);
      end
      chk("fetch_seen", 32'(found), 32'd1);
   endtask

   task automatic end_test();
      chk("fetch_queue_empty", 32'(fetch_q.size()), 32'd0);
      chk("write_queue_empty", 32'(wr_q.size()), 32'd0);
      fetch_q.delete();
      wr_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) imem[i] = {1'b0, OpTba, 4'd0};
      #1;
      // Reset state while held in reset
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_status", 32'({busy, halted, ov_flag}), 32'd0);
      chk("rst_strobes", 32'({imem_req, acc_we, reg_we, acc_src_mem, dmem_req, dmem_we}), 32'd0);
      chk("rst_ir", 32'({alu_type, alu_op, reg_addr}), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // take r1; add r2; halt with overflow on the add
      do_reset();
      imem[0] = {1'b0, OpTake, 4'd1};
      imem[1] = {1'b0, OpAdd, 4'd2};
      imem[2] = {1'b0, OpHalt, 4'd0};
      ov_in = 1'b1;
      push_fetch_range(0, 2);
      push_wr(1, 0, 0, 0, 4'd1, 8'd0, 0);
      push_wr(1, 0, 0, 0, 4'd2, 8'd1, 0);
      pulse_start();
      wait_halt(n);
      // Halt is entered seven edges after start is sampled; one edge is spent in pulse_start.
      chk("halt_latency", 32'(n), 32'd6);
      chk("prog1_pc", 32'(pc), 32'd2);
      chk("prog1_ov", 32'(ov_flag), 32'd1);
      chk("prog1_busy", 32'(busy), 32'd0);
      end_test();

      // Overflow flag kept across xor, cleared by of0
      do_reset();
      imem[0] = {1'b0, OpAdd, 4'd0};
      imem[1] = {1'b0, OpXor, 4'd1};
      imem[2] = {1'b0, OpTake, 4'd3};
      imem[3] = {1'b0, OpOf0, 4'd0};
      imem[4] = {1'b0, OpTake, 4'd4};
      imem[5] = {1'b0, OpHalt, 4'd0};
      ov_in = 1'b1;
      push_fetch_range(0, 5);
      push_wr(1, 0, 0, 0, 4'd0, 8'd0, 0);
      push_wr(1, 0, 0, 0, 4'd1, 8'd1, 1);
      push_wr(1, 0, 0, 0, 4'd3, 8'd2, 1);
      push_wr(1, 0, 0, 0, 4'd4, 8'd4, 0);
      pulse_start();
      wait_halt(n);
      chk("ov_after_of0", 32'(ov_flag), 32'd0);
      chk("prog2_pc", 32'(pc), 32'd5);
      end_test();

      // store r3 with 3 wait cycles, then load r4 with none
      do_reset();
      imem[0] = {1'b0, OpStore, 4'd3};
      imem[1] = {1'b0, OpLoad, 4'd4};
      imem[2] = {1'b0, OpHalt, 4'd0};
      st_delay = 3;
      push_fetch_range(0, 2);
      push_wr(0, 0, 1, 0, 4'd3, 8'd0, 0);
      push_wr(1, 0, 0, 1, 4'd4, 8'd1, 0);
      pulse_start();
      wait_halt(n);
      chk("dmem_req_cycles", 32'(dreq_cycles), 32'd5);
      chk("dmem_we_cycles", 32'(dwe_cycles), 32'd4);
      chk("prog3_pc", 32'(pc), 32'd2);
      end_test();

      // Branch at PC 5 by -5: taken once, then not taken
      do_reset();
      imem[5] = 9'h1FB;
      imem[6] = {1'b0, OpHalt, 4'd0};
      acc_nz = 1'b1;
      push_fetch_range(0, 5);
      push_fetch_range(0, 6);
      pulse_start();
      wait_fetch(8'd5);
      @(posedge clk);
      wait_fetch(8'd5);
      acc_nz = 1'b0;
      tick(1);
      wait_halt(n);
      chk("branch_pc", 32'(pc), 32'd6);
      end_test();

      // Negative wrap 0 -> 255, then not-taken branch at 255 wraps to 0
      do_reset();
      imem[0]   = 9'h1FF;
      imem[1]   = {1'b0, OpHalt, 4'd0};
      imem[255] = 9'h1FB;
      acc_nz = 1'b1;
      fetch_q.push_back(8'd0);
      fetch_q.push_back(8'd255);
      fetch_q.push_back(8'd0);
      fetch_q.push_back(8'd1);
      pulse_start();
      wait_fetch(8'd255);
      acc_nz = 1'b0;
      tick(1);
      wait_halt(n);
      chk("wrap_pc", 32'(pc), 32'd1);
      end_test();

      // Reset asserted while a load waits for memory
      do_reset();
      imem[2] = {1'b0, OpLoad, 4'd5};
      imem[3] = {1'b0, OpHalt, 4'd0};
      ld_delay = 20;
      push_fetch_range(0, 2);
      pulse_start();
      n = 0;
      while (!dmem_req && n < 50) begin
         tick(1);
         n++;
      end
      chk("mem_entered", 32'({dmem_req, pc}), 32'h102);
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("midrst_pc", 32'(pc), 32'd0);
      chk("midrst_status", 32'({busy, halted, ov_flag}), 32'd0);
      chk("midrst_strobes", 32'({imem_req, acc_we, reg_we, acc_src_mem, dmem_req, dmem_we}),
          32'd0);
      chk("midrst_ir", 32'({alu_type, alu_op, reg_addr}), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      chk("post_rst_idle", 32'({busy, acc_we, reg_we, dmem_req, dmem_we}), 32'd0);
      ld_delay = 0;
      push_fetch_range(0, 3);
      push_wr(1, 0, 0, 1, 4'd5, 8'd2, 0);
      pulse_start();
      wait_halt(n);
      chk("restart_pc", 32'(pc), 32'd3);
      end_test();

      // start ignored in FETCH (stalled at PC 1) and in HALT
      do_reset();
      imem[1] = {1'b0, OpPut, 4'd7};
      imem[2] = {1'b0, OpHalt, 4'd0};
      stall_en = 1'b1;
      stall_pc = 8'd1;
      push_fetch_range(0, 2);
      push_wr(0, 1, 0, 0, 4'd7, 8'd1, 0);
      pulse_start();
      n = 0;
      while (!(imem_req && pc == 8'd1) && n < 50) begin
         tick(1);
         n++;
      end
      pulse_start();
      tick(2);
      chk("fetch_start_ignored", 32'({imem_req, busy, pc}), 32'h301);
      stall_en = 1'b0;
      wait_halt(n);
      pulse_start();
      tick(3);
      chk("halt_start_ignored", 32'({halted, busy, pc}), 32'h202);
      end_test();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
